// File: rtl/mem_block_mover_if.sv
// Data-memory port bundle driven by mem_block_mover.
// Byte address, 16-bit big-endian word data, separate read/write strobes.
interface mem_block_mover_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport master (
        output mem_address,
        output mem_write_data,
        output mem_write,
        output mem_read,
        input  mem_read_data
    );

    modport slave (
        input  mem_address,
        input  mem_write_data,
        input  mem_write,
        input  mem_read,
        output mem_read_data
    );
endinterface

// File: rtl/mem_block_mover.sv
// Block copy engine on the data-memory port: read word, write word, stride 2.
// Optional fill mode (write a constant pattern) enabled by MEM_BLOCK_MOVER_FILL_EN.
module mem_block_mover #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [LEN_W-1:0]  length,
`ifdef MEM_BLOCK_MOVER_FILL_EN
    input  logic              fill,
    input  logic [DATA_W-1:0] fill_value,
`endif
    output logic              busy,
    output logic              done,
    mem_block_mover_if.master mem
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              fill_q, fill_d;

    // State and datapath registers; reset aborts any transfer at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            addr_q  <= '0;
            count_q <= '0;
            buf_q   <= '0;
            fill_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            addr_q  <= addr_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            fill_q  <= fill_d;
        end
    end

    // Next-state and strobe decode; address holds its last value when idle.
    always_comb begin
        state_d            = state_q;
        src_d              = src_q;
        dst_d              = dst_q;
        addr_d             = addr_q;
        count_d            = count_q;
        buf_d              = buf_q;
        fill_d             = fill_q;
        busy               = 1'b0;
        done               = 1'b0;
        mem.mem_read       = 1'b0;
        mem.mem_write      = 1'b0;
        mem.mem_address    = addr_q;
        mem.mem_write_data = buf_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    count_d = length;
`ifdef MEM_BLOCK_MOVER_FILL_EN
                    fill_d  = fill;
                    if (fill) begin
                        buf_d = fill_value;
                    end
                    if (length == '0) begin
                        state_d = S_DONE;
                    end else if (fill) begin
                        state_d = S_WRITE;
                    end else begin
                        state_d = S_READ;
                    end
`else
                    fill_d  = 1'b0;
                    state_d = (length == '0) ? S_DONE : S_READ;
`endif
                end
            end
            S_READ: begin
                busy            = 1'b1;
                mem.mem_read    = 1'b1;
                mem.mem_address = src_q;
                addr_d          = src_q;
                buf_d           = mem.mem_read_data;
                src_d           = src_q + ADDR_W'(2);
                state_d         = S_WRITE;
            end
            S_WRITE: begin
                busy            = 1'b1;
                mem.mem_write   = 1'b1;
                mem.mem_address = dst_q;
                addr_d          = dst_q;
                dst_d           = dst_q + ADDR_W'(2);
                count_d         = count_q - LEN_W'(1);
                if (count_q == LEN_W'(1)) begin
                    state_d = S_DONE;
                end else if (fill_q) begin
                    state_d = S_WRITE;
                end else begin
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
endmodule
